commit_sequencer: RTL and testbench

COMMIT_SEQUENCER -- requirements
Module: commit_sequencer

---
 rtl/commit_sequencer_pkg.sv | 50 +++++
 rtl/commit_sequencer.sv | 113 +++++++++++
 tb/tb_commit_sequencer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/commit_sequencer_pkg.sv
// lc3b_types: opcode/register types, commit FSM states and the opcode
// classification shared by the commit sequencer.
package lc3b_types;

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode;

  typedef logic [2:0] lc3b_reg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STORE,
    S_FLUSH
  } commit_state_t;

  typedef enum logic [1:0] {
    CLS_REG,
    CLS_STORE,
    CLS_BRANCH,
    CLS_NONE
  } commit_class_t;

  // JSR/TRAP write R7; RTI and STI retire with no architectural side effect here.
  function automatic commit_class_t classify(input lc3b_opcode op);
    case (op)
      op_add, op_and, op_not, op_shf, op_lea,
      op_ldb, op_ldr, op_ldi, op_jsr, op_trap: classify = CLS_REG;
      op_stb, op_str:                          classify = CLS_STORE;
      op_br, op_jmp:                           classify = CLS_BRANCH;
      default:                                 classify = CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/commit_sequencer.sv
// ROB-head commit sequencer: regfile writeback, store handshake with L1 and
// mispredict flush. Optional retired-instruction counter via COMMIT_COUNT_EN.
module commit_sequencer
  import lc3b_types::*;
#(
  parameter int data_width = 16,
  parameter int tag_width  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  head_valid,
  input  logic                  head_ready,
  input  lc3b_opcode            head_opcode,
  input  lc3b_reg               head_dest,
  input  logic [data_width-1:0] head_value,
  input  logic [data_width-1:0] head_addr,
  input  logic                  head_mispredict,
  input  logic                  dmem_resp,
  output lc3b_reg               dest_a,
  output logic [data_width-1:0] value_out,
  output logic                  ld_regfile_value,
  output logic                  ld_regfile_busy,
  output logic                  dmem_write,
  output logic [data_width-1:0] dmem_address,
  output logic [data_width-1:0] dmem_wdata,
  output logic                  RE_out,
  output logic                  flush,
  output logic [15:0]           commit_count
);

  if (tag_width < 1) begin : g_tag_width_invalid
    $error("tag_width must be at least 1");
  end

  commit_state_t state;
  commit_class_t head_class;
  logic          head_go;

  assign head_class = classify(head_opcode);
  assign head_go    = head_valid && head_ready;

  // Commit strobes are suppressed while reset is asserted so an abandoned
  // store cannot dequeue on a late dmem_resp.
  always_comb begin
    ld_regfile_value = 1'b0;
    ld_regfile_busy  = 1'b0;
    RE_out           = 1'b0;
    dest_a           = '0;
    value_out        = '0;
    if (rst_n) begin
      case (state)
        S_IDLE: begin
          if (head_go) begin
            case (head_class)
              CLS_REG: begin
                ld_regfile_value = 1'b1;
                ld_regfile_busy  = 1'b1;
                RE_out           = 1'b1;
                dest_a           = head_dest;
                value_out        = head_value;
              end
              CLS_BRANCH, CLS_NONE: RE_out = 1'b1;
              default: ;
            endcase
          end
        end
        S_STORE: RE_out = dmem_resp;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      dmem_address <= '0;
      dmem_wdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (head_go) begin
            if (head_class == CLS_STORE) begin
              dmem_address <= head_addr;
              dmem_wdata   <= head_value;
              state        <= S_STORE;
            end else if (head_class == CLS_BRANCH && head_mispredict) begin
              state <= S_FLUSH;
            end
          end
        end
        S_STORE: if (dmem_resp) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dmem_write = (state == S_STORE);
  assign flush      = (state == S_FLUSH);

`ifdef COMMIT_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n)      count_q <= '0;
    else if (RE_out) count_q <= count_q + 16'd1;
  end

  assign commit_count = count_q;
`else
  assign commit_count = '0;
`endif

endmodule

// File: tb/tb_commit_sequencer.sv
// Self-checking bench for commit_sequencer: directed scenarios plus random
// traffic compared against a cycle-level behavioural model.
module tb_commit_sequencer;
  import lc3b_types::*;

  localparam int DW = 16;
  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          head_valid, head_ready, head_mispredict, dmem_resp;
  lc3b_opcode    head_opcode;
  lc3b_reg       head_dest;
  logic [DW-1:0] head_value, head_addr;
  lc3b_reg       dest_a;
  logic [DW-1:0] value_out, dmem_address, dmem_wdata;
  logic          ld_regfile_value, ld_regfile_busy, dmem_write, RE_out, flush;
  logic [15:0]   commit_count;

  always #5 clk = ~clk;

  commit_sequencer #(.data_width(DW), .tag_width(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .head_valid(head_valid), .head_ready(head_ready),
    .head_opcode(head_opcode), .head_dest(head_dest),
    .head_value(head_value), .head_addr(head_addr),
    .head_mispredict(head_mispredict), .dmem_resp(dmem_resp),
    .dest_a(dest_a), .value_out(value_out),
    .ld_regfile_value(ld_regfile_value), .ld_regfile_busy(ld_regfile_busy),
    .dmem_write(dmem_write), .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
    .RE_out(RE_out), .flush(flush), .commit_count(commit_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a store in flight, a pending flush, the latched store bus, retired count.
  bit          m_store, m_flush;
  logic [15:0] m_addr, m_data;
  int unsigned m_count;

  logic        obs_re, obs_ld, obs_dw, obs_flush;
  logic [2:0]  obs_dest;
  logic [15:0] obs_val;

  // 0 = writes a register, 1 = store, 2 = branch/jump, 3 = retire only
  function automatic int kind_of(input int op);
    case (op)
      1, 2, 4, 5, 6, 9, 10, 13, 14, 15: return 0;
      3, 7:                             return 1;
      0, 12:                            return 2;
      default:                          return 3;
    endcase
  endfunction

  task automatic cycle();
    logic        exp_re, exp_ld;
    logic [2:0]  exp_dest;
    logic [15:0] exp_val, exp_cnt;
    int          k;
    #2;
    k = kind_of(int'(head_opcode));
    exp_re = 1'b0; exp_ld = 1'b0; exp_dest = '0; exp_val = '0;
    if (rst_n) begin
      if (m_store) exp_re = dmem_resp;
      else if (!m_flush && head_valid && head_ready) begin
        if (k == 0) begin
          exp_ld = 1'b1; exp_re = 1'b1; exp_dest = head_dest; exp_val = head_value;
        end else if (k != 1) exp_re = 1'b1;
      end
    end
`ifdef COMMIT_COUNT_EN
    exp_cnt = m_count[15:0];
`else
    exp_cnt = 16'h0000;
`endif
    check("re_out", RE_out, exp_re);
    check("ld_value", ld_regfile_value, exp_ld);
    check("ld_busy", ld_regfile_busy, exp_ld);
    check("dest_a", dest_a, exp_dest);
    check("value_out", value_out, exp_val);
    check("dmem_write", dmem_write, m_store);
    check("dmem_address", dmem_address, m_addr);
    check("dmem_wdata", dmem_wdata, m_data);
    check("flush", flush, m_flush);
    check("commit_count", commit_count, exp_cnt);
    obs_re = RE_out; obs_ld = ld_regfile_value; obs_dw = dmem_write;
    obs_flush = flush; obs_dest = dest_a; obs_val = value_out;
    @(posedge clk);
    if (!rst_n) begin
      m_store = 0; m_flush = 0; m_addr = '0; m_data = '0; m_count = 0;
    end else begin
      m_count = (m_count + (exp_re ? 1 : 0)) % 65536;
      if (m_store) m_store = !dmem_resp;
      else if (m_flush) m_flush = 0;
      else if (head_valid && head_ready) begin
        if (k == 1) begin
          m_store = 1; m_addr = head_addr; m_data = head_value;
        end else if (k == 2 && head_mispredict) m_flush = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic quiet();
    head_valid = 0; head_ready = 0; head_opcode = op_add; head_dest = '0;
    head_value = '0; head_addr = '0; head_mispredict = 0; dmem_resp = 0;
  endtask

  task automatic head(input lc3b_opcode op, input int dst, input int val, input int adr, input bit misp);
    head_valid = 1; head_ready = 1; head_opcode = op; head_dest = lc3b_reg'(dst);
    head_value = DW'(val); head_addr = DW'(adr); head_mispredict = misp;
  endtask

  initial begin
    int dw_cnt, re_cnt;
    m_store = 0; m_flush = 0; m_addr = '0; m_data = '0; m_count = 0;
    quiet();
    rst_n = 0;
    @(negedge clk);
    cycle(); cycle();
    rst_n = 1;
    check("reset_count", commit_count, 0);
    check("reset_dwrite", dmem_write, 0);

    // ADD R3 <- 0x1234 commits in the same cycle
    head(op_add, 3, 'h1234, 0, 0);
    cycle();
    check("add_re", obs_re, 1);
    check("add_dest", obs_dest, 3);
    check("add_val", obs_val, 'h1234);

    // STR to 0x0040, response on the fourth store cycle
    head(op_str, 0, 'hBEEF, 'h0040, 0);
    cycle();
    check("str_issue_re", obs_re, 0);
    dw_cnt = 0; re_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      dmem_resp = (i == 3);
      cycle();
      dw_cnt += int'(obs_dw); re_cnt += int'(obs_re);
      check("str_addr_hold", dmem_address, 'h0040);
      check("str_data_hold", dmem_wdata, 'hBEEF);
      if (i == 3) check("str_resp_re", obs_re, 1);
    end
    quiet();
    cycle();
    check("str_dw_cycles", dw_cnt, 4);
    check("str_re_count", re_cnt, 1);
    check("str_dw_after", obs_dw, 0);

    // mispredicted branch: dequeue, then one flush cycle with no commit
    head(op_br, 0, 0, 0, 1);
    cycle();
    check("br_re", obs_re, 1);
    check("br_no_flush_yet", obs_flush, 0);
    head(op_add, 5, 'h0077, 0, 0);
    cycle();
    check("flush_hi", obs_flush, 1);
    check("flush_no_re", obs_re, 0);
    check("flush_no_ld", obs_ld, 0);
    cycle();
    check("flush_once", obs_flush, 0);
    check("post_flush_re", obs_re, 1);

    // reset in the middle of a store, then a spurious response
    head(op_stb, 0, 'h00AA, 'h1000, 0);
    cycle();
    quiet();
    cycle();
    check("mid_store_dw", obs_dw, 1);
    rst_n = 0; dmem_resp = 1;
    cycle();
    check("rst_store_re", obs_re, 0);
    rst_n = 1;
    cycle();
    check("rst_store_dw", obs_dw, 0);
    check("spurious_resp_re", obs_re, 0);

    // head valid but not ready for five cycles
    head(op_and, 6, 'h5A5A, 0, 0);
    head_ready = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_re", obs_re, 0);
      check("stall_ld", obs_ld, 0);
    end
    head_ready = 1;
    cycle();
    check("stall_release_re", obs_re, 1);
    check("stall_release_dest", obs_dest, 6);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      rst_n           = ($urandom_range(0, 99) >= 2);
      head_valid      = ($urandom_range(0, 3) != 0);
      head_ready      = ($urandom_range(0, 3) != 0);
      head_opcode     = lc3b_opcode'($urandom_range(0, 15));
      head_dest       = lc3b_reg'($urandom_range(0, 7));
      head_value      = DW'($urandom);
      head_addr       = DW'($urandom);
      head_mispredict = $urandom_range(0, 1);
      dmem_resp       = ($urandom_range(0, 9) < 3);
      cycle();
    end

`ifdef COMMIT_COUNT_EN
    // 0xFFFF commits then one more wraps the counter to zero
    quiet();
    rst_n = 0;
    cycle();
    rst_n = 1;
    head(op_add, 1, 'h0001, 0, 0);
    for (int i = 0; i < 65536; i++) cycle();
    quiet();
    cycle();
    check("count_wrap", commit_count, 0);
`else
    quiet();
    head(op_add, 2, 'h0002, 0, 0);
    cycle(); cycle();
    quiet();
    cycle();
    check("count_tied", commit_count, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
